mem_responder: RTL and testbench

Memory-side responder for the multicycle CPU's unified memory port (`adr`, `writedata`, `memwrite`, `readdata`). It has three jobs:
- Boot: hold the CPU in reset while a loader streams the program image into word RAM over a valid/ready handshake.
- Serve: answer CPU reads and writes.
- IO: decode one memory-mapped output register at `IO_ADDR`.

It sits between the testbench/board top and the processor, replacing separate imem/dmem models.

---
 rtl/mem_responder.sv | 137 +++++++++++++
 tb/tb_mem_responder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: unified memory port for the multicycle CPU.
// Boots a program image from a valid/ready loader into word RAM while holding
// the CPU in reset, then serves CPU reads/writes and one memory-mapped
// output register.
module mem_responder #(
  parameter int          DEPTH      = 64,
  parameter int          BOOT_WORDS = 64,
  parameter logic [31:0] IO_ADDR    = 32'hFFFF_FFFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  output logic        load_ready,
  output logic        cpu_reset,
  output logic        boot_done,
  input  logic [31:0] adr,
  input  logic [31:0] writedata,
  input  logic        memwrite,
  output logic [31:0] readdata,
  output logic [31:0] io_out,
  output logic        io_strobe,
  output logic        addr_err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_t;

  state_t        state;
  logic [AW-1:0] cnt;
  logic [31:0]   mem [DEPTH];

  logic          run;
  logic          io_hit;
  logic          ram_hit;
  logic [AW-1:0] idx;
  logic          transfer;
  logic          last_word;
  logic          cpu_wr;
  logic          unused_adr_bits;

  assign run       = (state == RUN);
  assign io_hit    = (adr == IO_ADDR);
  // Word index fits in the RAM only when every bit above it is zero.
  assign ram_hit   = (adr[31:AW+2] == '0);
  assign idx       = adr[AW+1:2];
  assign transfer  = load_valid && load_ready;
  assign last_word = (cnt == AW'(BOOT_WORDS - 1));
  assign cpu_wr    = run && memwrite;
  // Byte offset is ignored: every access is a full word.
  assign unused_adr_bits = ^adr[1:0];

  // Boot sequencing: count loader words, then release the CPU via one RELEASE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= BOOT;
      cnt        <= '0;
      load_ready <= 1'b1;
      cpu_reset  <= 1'b1;
      boot_done  <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          if (transfer) begin
            cnt <= cnt + 1'b1;
            if (last_word) begin
              state      <= RELEASE;
              load_ready <= 1'b0;
            end
          end
        end
        RELEASE: begin
          state     <= RUN;
          cpu_reset <= 1'b0;
          boot_done <= 1'b1;
        end
        RUN: begin
          state <= RUN;
        end
        default: begin
          state      <= BOOT;
          cnt        <= '0;
          load_ready <= 1'b1;
          cpu_reset  <= 1'b1;
          boot_done  <= 1'b0;
        end
      endcase
    end
  end

  // Word RAM write port: loader words during boot, CPU stores to RAM range in run.
  // Contents survive reset; the reset edge itself performs no write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (transfer) begin
        mem[cnt] <= load_data;
      end else if (cpu_wr && !io_hit && ram_hit) begin
        mem[idx] <= writedata;
      end
    end
  end

  // Output register, its write strobe, and the sticky out-of-range store flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      io_out    <= '0;
      io_strobe <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      io_strobe <= cpu_wr && io_hit;
      if (cpu_wr && io_hit) begin
        io_out <= writedata;
      end
      if (cpu_wr && !io_hit && !ram_hit) begin
        addr_err <= 1'b1;
      end
    end
  end

  // Combinational read path; the CPU samples it on its next edge.
  always_comb begin
    readdata = '0;
    if (run) begin
      if (io_hit) begin
        readdata = io_out;
      end else if (ram_hit) begin
        readdata = mem[idx];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: directed boot/run scenarios plus randomized
// CPU traffic, compared every cycle against a behavioural model.
module tb_mem_responder;

  localparam int          DEPTH = 64;
  localparam int          BW    = 4;
  localparam logic [31:0] IOA   = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_ready;
  logic        cpu_reset;
  logic        boot_done;
  logic [31:0] adr;
  logic [31:0] writedata;
  logic        memwrite;
  logic [31:0] readdata;
  logic [31:0] io_out;
  logic        io_strobe;
  logic        addr_err;

  mem_responder #(.DEPTH(DEPTH), .BOOT_WORDS(BW), .IO_ADDR(IOA)) dut (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .cpu_reset(cpu_reset), .boot_done(boot_done),
    .adr(adr), .writedata(writedata), .memwrite(memwrite), .readdata(readdata),
    .io_out(io_out), .io_strobe(io_strobe), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: words loaded so far, edges since the final boot word,
  // plus the architectural memory image and IO register.
  logic [31:0] m_mem   [DEPTH];
  bit          m_known [DEPTH];
  int          m_words;
  int          m_since;
  logic [31:0] m_io;
  bit          m_strobe;
  bit          m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_run();
    return m_since >= 1;
  endfunction

  // Called one time unit after a rising edge with inputs already driven:
  // checks outputs mid-cycle, then advances the model across the next edge.
  task automatic cycle();
    int i;
    bit run_now;
    #4;
    chk("load_ready", {31'b0, load_ready}, {31'b0, m_words < BW});
    chk("cpu_reset",  {31'b0, cpu_reset},  {31'b0, !m_run()});
    chk("boot_done",  {31'b0, boot_done},  {31'b0, m_run()});
    chk("io_out",     io_out, m_io);
    chk("io_strobe",  {31'b0, io_strobe},  {31'b0, m_strobe});
    chk("addr_err",   {31'b0, addr_err},   {31'b0, m_err});
    if (!m_run()) begin
      chk("readdata_idle", readdata, 32'h0);
    end else if (adr == IOA) begin
      chk("readdata_io", readdata, m_io);
    end else if ((adr >> 2) < DEPTH) begin
      i = int'(adr >> 2);
      if (m_known[i]) chk("readdata_ram", readdata, m_mem[i]);
    end else begin
      chk("readdata_oor", readdata, 32'h0);
    end

    @(posedge clk);
    run_now = m_run();
    if (reset) begin
      m_words  = 0;
      m_since  = -1;
      m_io     = '0;
      m_strobe = 1'b0;
      m_err    = 1'b0;
      $display("t=%0t reset", $time);
    end else begin
      m_strobe = run_now && memwrite && (adr == IOA);
      if (run_now && memwrite) begin
        $display("t=%0t cpu write adr=%h data=%h", $time, adr, writedata);
        if (adr == IOA) begin
          m_io = writedata;
        end else if ((adr >> 2) < DEPTH) begin
          i = int'(adr >> 2);
          m_mem[i]   = writedata;
          m_known[i] = 1'b1;
        end else begin
          m_err = 1'b1;
        end
      end
      if (m_words < BW) begin
        if (load_valid) begin
          $display("t=%0t load word %0d = %h", $time, m_words, load_data);
          m_mem[m_words]   = load_data;
          m_known[m_words] = 1'b1;
          m_words++;
          if (m_words == BW) m_since = 0;
        end
      end else if (m_since < 100) begin
        m_since++;
      end
    end
    #1;
  endtask

  task automatic drive(input logic rst, input logic lv, input logic [31:0] ld,
                       input logic [31:0] a, input logic [31:0] wd, input logic mw);
    reset      = rst;
    load_valid = lv;
    load_data  = ld;
    adr        = a;
    writedata  = wd;
    memwrite   = mw;
    cycle();
  endtask

  // Random CPU address: mostly RAM, sometimes IO, sometimes out of range.
  function automatic logic [31:0] rand_adr();
    int sel;
    sel = int'($urandom_range(0, 9));
    if (sel < 6) return {24'b0, 6'($urandom_range(0, DEPTH - 1)), 2'($urandom)};
    if (sel < 8) return IOA;
    return 32'h0000_0100 + ($urandom & 32'h0FFF_FF00);
  endfunction

  logic [31:0] boot_img [4];
  bit          stall_pat [7];

  initial begin
    boot_img  = '{32'h2002_0005, 32'h2003_000C, 32'hAC02_0050, 32'h0800_0003};
    stall_pat = '{1, 0, 0, 1, 1, 0, 1};
    for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
    m_words = 0; m_since = -1; m_io = '0; m_strobe = 1'b0; m_err = 1'b0;

    // Bring the DUT out of an unknown state before checking anything.
    reset = 1'b1; load_valid = 1'b0; load_data = '0;
    adr = '0; writedata = '0; memwrite = 1'b0;
    @(posedge clk);
    #1;
    drive(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);

    // Partial boot of two words with random CPU noise, then reset mid-boot.
    for (int k = 0; k < 2; k++)
      drive(1'b0, 1'b1, $urandom, rand_adr(), $urandom, 1'($urandom));
    drive(1'b1, 1'b1, $urandom, 32'h0, 32'h0, 1'b0);

    // Boot with loader stalls; CPU stores during boot must be ignored.
    foreach (stall_pat[k])
      drive(1'b0, stall_pat[k], $urandom, rand_adr(), $urandom, 1'($urandom));
    for (int k = 0; k < 3; k++)
      drive(1'b0, 1'b1, $urandom, {28'b0, 2'(k), 2'b00}, 32'h0, 1'b0);

    // Reset from RUN, then boot back-to-back with the reference image.
    drive(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    for (int k = 0; k < 4; k++)
      drive(1'b0, 1'b1, boot_img[k], IOA, 32'h1234_5678, 1'b1);
    for (int k = 0; k < 2; k++)
      drive(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0);
    for (int k = 0; k < 4; k++)
      drive(1'b0, 1'b0, 32'h0, 32'(k * 4), 32'h0, 1'b0);

    // RAM store and read-back, IO store/read, out-of-range store/read.
    drive(1'b0, 1'b0, 32'h0, 32'h0000_0050, 32'h7, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 32'h0000_0050, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 32'h0, IOA, 32'hDEAD_BEEF, 1'b1);
    drive(1'b0, 1'b0, 32'h0, IOA, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 32'h0000_0050, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 32'h0000_0400, 32'h5555_AAAA, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 32'h0000_0400, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 32'h0000_0000, 32'h0, 1'b0);

    // Fill the rest of RAM so random reads always have a known expectation.
    for (int k = 4; k < DEPTH; k++)
      drive(1'b0, 1'b0, 32'h0, 32'(k * 4), $urandom, 1'b1);

    // Randomized traffic, including back-to-back IO stores.
    for (int k = 0; k < 300; k++)
      drive(1'b0, 1'($urandom), $urandom, rand_adr(), $urandom, 1'($urandom));

    // Reset from RUN clears IO state and the error flag.
    drive(1'b1, 1'b0, 32'h0, IOA, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 32'h0, IOA, 32'h0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
